accum_ctrl: RTL
===============

Name: accum_ctrl

Overview:
- Sequential controller for the switch-input decimal accumulator.
- Debounces three active-low push buttons (add, clear, preset) and applies exactly one accumulator operation per press.
- Holds a 20-bit binary running sum, saturated to six decimal digits.
- Converts the sum to packed BCD with an iterative shift-add-3 engine, one bit per cycle, and feeds stable digits to the existing seven-segment decoders.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable samples before a button level is accepted (1 ms at 50 MHz).
- SAT_MAX, 999999: largest displayable sum; the accumulator never exceeds it.
- ACC_W, 20: accumulator width in bits.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- btn_add_n  input  1  raw add button, active-low, asynchronous to clk.
- btn_clr_n  input  1  raw clear button, active-low.
- btn_max_n  input  1  raw preset-to-SAT_MAX button, active-low.
- sw  input  10  addend, unsigned 0..1023, sampled on the accepted add press.
- bcd  output  24  six packed BCD digits; [23:20] is the hundred-thousands digit, [3:0] is ones.
- bcd_valid  output  1  high when bcd reflects the current accumulator value.
- busy  output  1  high while a conversion is running.
- sat  output  1  sticky; set when an add clipped at SAT_MAX.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: acc=0, bcd=24'h000000, bcd_valid=1, busy=0, sat=0, FSM=IDLE, debouncers treat buttons as released.
- Input synchronisation: each raw button passes through a 2-flop synchroniser, then a debouncer.
  - The debouncer's accepted level changes only after DEBOUNCE_CYCLES identical synchronised samples.
  - A press event is a 1-cycle pulse on the accepted high-to-low transition. Holding a button produces no further events.
- Operation priority when events coincide in one cycle: clear > preset > add.
  - clear: acc=0, sat=0.
  - preset: acc=SAT_MAX.
  - add: acc = min(acc + sw, SAT_MAX). Compute with a 21-bit intermediate. If clipping occurs, sat=1.
- Any accumulator write sets an internal dirty flag and drives bcd_valid low in the following cycle.
- Accumulator writes are accepted in every FSM state. They are never blocked by a conversion.
- FSM:
  - IDLE: if dirty, snapshot acc into a shift register, clear dirty, zero the scratch digits, bit counter=ACC_W-1, go to SHIFT.
  - SHIFT (ACC_W cycles): per cycle, add 3 to each scratch digit ≥5, then shift {digits, shreg} left by 1. After the cycle with counter=0, go to DONE.
  - DONE (1 cycle): bcd <= scratch digits. bcd_valid <= ~dirty. Return to IDLE.
- busy=1 in SHIFT and DONE.
- Latency: from the accumulator write to bcd update is 1 (IDLE) + 20 (SHIFT) + 1 (DONE) = 22 cycles.
- Writes during a conversion: the current conversion completes using the stale snapshot. bcd updates but bcd_valid stays 0. A new conversion starts automatically from IDLE. No event is lost, and bcd never shows a partially converted value.
- Reset mid-conversion: abort immediately to the reset values. The conversion is discarded.
- sw changing while no add event is present has no effect.

Optional Feature:
- Macro: ACCUM_WRAP_EN.
- Defined: add wraps modulo SAT_MAX+1. Example: 999900 + 200 = 100. sat is set on wrap and cleared only by clear or reset.
- Undefined: saturating behaviour as above.
- Preset and clear behave the same in both builds.

Decomposition:
- Shared package accum_pkg holds:
  - state enum {IDLE, SHIFT, DONE};
  - constants ACC_W=20, BCD_DIGITS=6, BCD_W=24, SAT_MAX=20'd999999;
  - BCD digit typedef (4-bit).
- Sub-module btn_debounce contains the synchroniser, stable counter and falling-edge pulse, parameterised by DEBOUNCE_CYCLES. accum_ctrl instantiates it three times.
- The double-dabble step stays inline in accum_ctrl.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Reset, then sw=10'd1000 and one clean add press → 22 cycles after the event, bcd=24'h001000, bcd_valid=1, sat=0.
- Ten add presses with sw=10'd1023 → bcd=24'h010230. A single press bouncing 3 times within 4 cycles counts once.
- Preset press, then add with sw=5 → bcd=24'h999999, sat=1. With ACCUM_WRAP_EN defined: bcd=24'h000004, sat=1.
- Clear and add pressed in the same cycle (sw=7) → bcd=24'h000000, sat=0.
- Add (sw=3) issued on cycle 5 of an ongoing conversion of 500 → intermediate bcd=24'h000500 with bcd_valid=0, then bcd=24'h000503 with bcd_valid=1, and busy deasserts.
- rst asserted during SHIFT → the next cycle shows acc=0, bcd=0, bcd_valid=1, busy=0. A subsequent add of 42 yields 24'h000042.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared types and constants for the decimal accumulator controller.
package accum_pkg;

  localparam int ACC_W      = 20;
  localparam int BCD_DIGITS = 6;
  localparam int BCD_W      = 24;
  localparam int BIT_CNT_W  = $clog2(ACC_W);

  localparam logic [ACC_W-1:0] SAT_MAX = 20'd999999;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Double-dabble correction: any digit of 5 or more gets +3 before the shift.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] digits);
    logic [BCD_W-1:0] result;
    bcd_digit_t       d;
    result = digits;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      d = digits[i*4 +: 4];
      if (d >= 4'd5) result[i*4 +: 4] = d + 4'd3;
    end
    return result;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stable-sample debouncer and press pulse for one
// active-low push button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_a;
  logic             sync_b;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // The counter tracks consecutive samples that disagree with the accepted
  // level; any agreeing sample restarts it, so bounces never get through.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
      level  <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_a <= btn_n;
      sync_b <= sync_a;
      press  <= 1'b0;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync_b;
        cnt   <= '0;
        press <= ~sync_b;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/accum_ctrl.sv
// Debounced-button decimal accumulator with an iterative binary-to-BCD engine.
// Optional build macro ACCUM_WRAP_EN: add wraps modulo SAT_MAX+1 instead of saturating.
module accum_ctrl
  import accum_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_add_n,
  input  logic             btn_clr_n,
  input  logic             btn_max_n,
  input  logic [9:0]       sw,
  output logic [BCD_W-1:0] bcd,
  output logic             bcd_valid,
  output logic             busy,
  output logic             sat
);

  logic add_ev, clr_ev, max_ev;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_add (
    .clk(clk), .rst(rst), .btn_n(btn_add_n), .press(add_ev));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk(clk), .rst(rst), .btn_n(btn_clr_n), .press(clr_ev));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_max (
    .clk(clk), .rst(rst), .btn_n(btn_max_n), .press(max_ev));

  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_next;
  logic [ACC_W:0]       sum;
  logic                 sat_next;
  logic                 acc_wr;
  state_t               state;
  logic                 dirty;
  logic [ACC_W-1:0]     shreg;
  logic [BCD_W-1:0]     digits;
  logic [BIT_CNT_W-1:0] bit_cnt;

  // Event priority is clear > preset > add; an out-of-range sum is clipped or wrapped.
  always_comb begin
    sum      = {1'b0, acc} + {{(ACC_W + 1 - 10){1'b0}}, sw};
    acc_next = acc;
    sat_next = sat;
    acc_wr   = 1'b0;
    if (clr_ev) begin
      acc_next = '0;
      sat_next = 1'b0;
      acc_wr   = 1'b1;
    end else if (max_ev) begin
      acc_next = SAT_MAX;
      acc_wr   = 1'b1;
    end else if (add_ev) begin
      acc_wr = 1'b1;
      if (sum > {1'b0, SAT_MAX}) begin
`ifdef ACCUM_WRAP_EN
        acc_next = ACC_W'(sum - ({1'b0, SAT_MAX} + 21'd1));
`else
        acc_next = SAT_MAX;
`endif
        sat_next = 1'b1;
      end else begin
        acc_next = sum[ACC_W-1:0];
      end
    end
  end

  // Writes never wait for the converter; dirty forces another pass after the
  // current one, and bcd only ever loads a fully converted snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      sat       <= 1'b0;
      dirty     <= 1'b0;
      state     <= IDLE;
      shreg     <= '0;
      digits    <= '0;
      bit_cnt   <= '0;
      bcd       <= '0;
      bcd_valid <= 1'b1;
      busy      <= 1'b0;
    end else begin
      acc <= acc_next;
      sat <= sat_next;
      if (acc_wr) begin
        dirty     <= 1'b1;
        bcd_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (dirty) begin
            shreg   <= acc;
            digits  <= '0;
            bit_cnt <= BIT_CNT_W'(ACC_W - 1);
            state   <= SHIFT;
            busy    <= 1'b1;
            if (!acc_wr) dirty <= 1'b0;
          end
        end
        SHIFT: begin
          {digits, shreg} <= {dabble_adjust(digits), shreg} << 1;
          if (bit_cnt == '0) state <= DONE;
          else bit_cnt <= bit_cnt - BIT_CNT_W'(1);
        end
        DONE: begin
          bcd       <= digits;
          bcd_valid <= ~(dirty | acc_wr);
          state     <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
